// File: rtl/axi_cfg_pkg.sv
// Shared definitions for the AXI config read/write bridges: burst and
// response encodings plus the bridge FSM state encoding.
package axi_cfg_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_RESP = 2'd2
   } cfg_state_t;

endpackage

// File: rtl/axi_config_wr.sv
// AXI4 write slave turning one AW/W burst at a time into single-cycle register
// write strobes; all outputs registered, one beat per cycle, B after the last beat.
module axi_config_wr
   import axi_cfg_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STRB_WIDTH   = DATA_WIDTH / 8,
   parameter int ID_WIDTH     = 8,
   parameter int AWUSER_WIDTH = 1,
   parameter int BUSER_WIDTH  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ID_WIDTH-1:0]     s_axi_awid,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [7:0]              s_axi_awlen,
   input  logic [2:0]              s_axi_awsize,
   input  logic [1:0]              s_axi_awburst,
   input  logic                    s_axi_awlock,
   input  logic [3:0]              s_axi_awcache,
   input  logic [2:0]              s_axi_awprot,
   input  logic [3:0]              s_axi_awqos,
   input  logic [3:0]              s_axi_awregion,
   input  logic [AWUSER_WIDTH-1:0] s_axi_awuser,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [STRB_WIDTH-1:0]   s_axi_wstrb,
   input  logic                    s_axi_wlast,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [ID_WIDTH-1:0]     s_axi_bid,
   output logic [1:0]              s_axi_bresp,
   output logic [BUSER_WIDTH-1:0]  s_axi_buser,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   output logic                    wr,
   output logic [ADDR_WIDTH-1:0]   waddr,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [STRB_WIDTH-1:0]   wstrb
);

   cfg_state_t              r_state,   w_state_nxt;
   logic                    r_awready, w_awready_nxt;
   logic                    r_wready,  w_wready_nxt;
   logic                    r_bvalid,  w_bvalid_nxt;
   logic [ID_WIDTH-1:0]     r_bid,     w_bid_nxt;
   logic [1:0]              r_bresp,   w_bresp_nxt;
   logic                    r_wr,      w_wr_nxt;
   logic [ADDR_WIDTH-1:0]   r_waddr,   w_waddr_nxt;
   logic [DATA_WIDTH-1:0]   r_wdata,   w_wdata_nxt;
   logic [STRB_WIDTH-1:0]   r_wstrb,   w_wstrb_nxt;
   logic [ID_WIDTH-1:0]     r_id,      w_id_nxt;
   logic [ADDR_WIDTH-1:0]   r_addr,    w_addr_nxt;
   logic [7:0]              r_len,     w_len_nxt;
   logic [1:0]              r_burst,   w_burst_nxt;
   logic [7:0]              r_cnt,     w_cnt_nxt;
   logic                    r_err,     w_err_nxt;

   logic w_final;
   logic w_beat_err;
   logic w_unused_ok;

   // Beat count alone decides the end of the burst; wlast is only cross-checked.
   assign w_final    = (r_cnt == r_len);
   assign w_beat_err = (s_axi_wlast != w_final);

   assign w_unused_ok = ^{s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                          s_axi_awqos, s_axi_awregion, s_axi_awuser};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bid     <= '0;
         r_bresp   <= '0;
         r_wr      <= 1'b0;
         r_waddr   <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_id      <= '0;
         r_addr    <= '0;
         r_len     <= '0;
         r_burst   <= '0;
         r_cnt     <= '0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_awready <= w_awready_nxt;
         r_wready  <= w_wready_nxt;
         r_bvalid  <= w_bvalid_nxt;
         r_bid     <= w_bid_nxt;
         r_bresp   <= w_bresp_nxt;
         r_wr      <= w_wr_nxt;
         r_waddr   <= w_waddr_nxt;
         r_wdata   <= w_wdata_nxt;
         r_wstrb   <= w_wstrb_nxt;
         r_id      <= w_id_nxt;
         r_addr    <= w_addr_nxt;
         r_len     <= w_len_nxt;
         r_burst   <= w_burst_nxt;
         r_cnt     <= w_cnt_nxt;
         r_err     <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_awready_nxt = r_awready;
      w_wready_nxt  = r_wready;
      w_bvalid_nxt  = r_bvalid;
      w_bid_nxt     = r_bid;
      w_bresp_nxt   = r_bresp;
      w_wr_nxt      = 1'b0;
      w_waddr_nxt   = r_waddr;
      w_wdata_nxt   = r_wdata;
      w_wstrb_nxt   = r_wstrb;
      w_id_nxt      = r_id;
      w_addr_nxt    = r_addr;
      w_len_nxt     = r_len;
      w_burst_nxt   = r_burst;
      w_cnt_nxt     = r_cnt;
      w_err_nxt     = r_err;

      case (r_state)
         ST_IDLE: begin
            // awready comes up one cycle after reset or after the B handshake.
            w_awready_nxt = 1'b1;
            w_wready_nxt  = 1'b0;
            w_bvalid_nxt  = 1'b0;
            if (s_axi_awvalid && r_awready) begin
               w_id_nxt      = s_axi_awid;
               w_addr_nxt    = s_axi_awaddr;
               w_len_nxt     = s_axi_awlen;
               w_burst_nxt   = s_axi_awburst;
               w_cnt_nxt     = '0;
               w_err_nxt     = 1'b0;
               w_awready_nxt = 1'b0;
               w_wready_nxt  = 1'b1;
               w_state_nxt   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (s_axi_wvalid && r_wready) begin
               w_wr_nxt    = 1'b1;
               w_waddr_nxt = r_addr;
               w_wdata_nxt = s_axi_wdata;
               w_wstrb_nxt = s_axi_wstrb;
               w_err_nxt   = r_err | w_beat_err;
               if (r_burst != BURST_FIXED)
                  w_addr_nxt = r_addr + ADDR_WIDTH'(STRB_WIDTH);
               if (w_final) begin
                  w_wready_nxt = 1'b0;
                  w_bvalid_nxt = 1'b1;
                  w_bid_nxt    = r_id;
                  w_bresp_nxt  = (r_err | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                  w_state_nxt  = ST_RESP;
               end else begin
                  w_cnt_nxt = r_cnt + 8'd1;
               end
            end
         end
         ST_RESP: begin
            if (s_axi_bready) begin
               w_bvalid_nxt  = 1'b0;
               w_awready_nxt = 1'b1;
               w_state_nxt   = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt   = ST_IDLE;
            w_awready_nxt = 1'b0;
            w_wready_nxt  = 1'b0;
            w_bvalid_nxt  = 1'b0;
         end
      endcase
   end

   assign s_axi_awready = r_awready;
   assign s_axi_wready  = r_wready;
   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bid     = r_bid;
   assign s_axi_bresp   = r_bresp;
   assign s_axi_buser   = '0;
   assign wr            = r_wr;
   assign waddr         = r_waddr;
   assign wdata         = r_wdata;
   assign wstrb         = r_wstrb;

endmodule

// File: tb/tb_axi_config_wr.sv
// Directed plus randomized bursts for axi_config_wr, checked against a
// burst-level model of the expected register writes and B responses.
module tb_axi_config_wr;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  awid = '0;
   logic [31:0] awaddr = '0;
   logic [7:0]  awlen = '0;
   logic [1:0]  awburst = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdat = '0;
   logic [3:0]  wstb = '0;
   logic        wlast = 1'b0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [7:0]  bid;
   logic [1:0]  bresp;
   logic [0:0]  buser;
   logic        bvalid;
   logic        bready = 1'b0;
   logic        wr;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;

   int n_total = 0;
   int n_pass  = 0;

   logic [31:0] exp_addr[$], exp_data[$], mon_addr[$], mon_data[$];
   logic [3:0]  exp_strb[$], mon_strb[$];

   axi_config_wr dut (
      .clk(clk), .rst(rst),
      .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
      .s_axi_awsize(3'd2), .s_axi_awburst(awburst), .s_axi_awlock(1'b0),
      .s_axi_awcache(4'd0), .s_axi_awprot(3'd0), .s_axi_awqos(4'd0),
      .s_axi_awregion(4'd0), .s_axi_awuser(1'b0),
      .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdat), .s_axi_wstrb(wstb), .s_axi_wlast(wlast),
      .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_buser(buser),
      .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .wr(wr), .waddr(waddr), .wdata(wdata), .wstrb(wstrb)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr === 1'b1) begin
         mon_addr.push_back(waddr);
         mon_data.push_back(wdata);
         mon_strb.push_back(wstrb);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
   endtask

   task automatic clear_q();
      exp_addr.delete(); exp_data.delete(); exp_strb.delete();
      mon_addr.delete(); mon_data.delete(); mon_strb.delete();
   endtask

   task automatic compare_writes(input string tag);
      check({tag, " nwr"}, 64'(mon_addr.size()), 64'(exp_addr.size()));
      for (int i = 0; i < exp_addr.size() && i < mon_addr.size(); i++) begin
         check($sformatf("%s waddr[%0d]", tag, i), 64'(mon_addr[i]), 64'(exp_addr[i]));
         check($sformatf("%s wdata[%0d]", tag, i), 64'(mon_data[i]), 64'(exp_data[i]));
         check($sformatf("%s wstrb[%0d]", tag, i), 64'(mon_strb[i]), 64'(exp_strb[i]));
      end
   endtask

   task automatic send_aw(input logic [7:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] burst);
      int t;
      check("idle wready", 64'(wready), 64'd0);
      awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
      t = 0;
      while (awready !== 1'b1 && t < 200) begin step(); t++; end
      check("awready", 64'(awready), 64'd1);
      step();
      awvalid = 1'b0;
      check("aw->wready", 64'(wready), 64'd1);
      check("aw->awready", 64'(awready), 64'd0);
   endtask

   // Model: FIXED keeps the start address, INCR/WRAP step by 4 modulo 2^32;
   // SLVERR iff any beat's wlast disagrees with "this is beat len".
   task automatic do_burst(input logic [7:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst,
                           input int err_beat, input int max_gap, input int bdelay,
                           input bit directed, input logic [31:0] data0);
      logic [1:0]  resp_exp;
      logic [31:0] a, d;
      logic [3:0]  s;
      int t;
      clear_q();
      resp_exp = 2'b00;
      send_aw(id, addr, len, burst);
      a = addr;
      for (int i = 0; i <= int'(len); i++) begin
         for (int g = $urandom_range(0, max_gap); g > 0; g--) begin
            wvalid = 1'b0;
            step();
         end
         d = directed ? data0 + 32'(i) : $urandom;
         s = directed ? 4'hF : 4'($urandom_range(0, 15));
         wdat = d; wstb = s; wvalid = 1'b1;
         wlast = (i == int'(len)) ^ (i == err_beat);
         if (wlast != (i == int'(len))) resp_exp = 2'b10;
         exp_addr.push_back(a); exp_data.push_back(d); exp_strb.push_back(s);
         if (burst != 2'b00) a = a + 32'd4;
         t = 0;
         while (wready !== 1'b1 && t < 200) begin step(); t++; end
         check("beat wready", 64'(wready), 64'd1);
         check("bvalid early", 64'(bvalid), 64'd0);
         step();
      end
      wvalid = 1'b0; wlast = 1'b0;
      check("last wr", 64'(wr), 64'd1);
      check("bvalid", 64'(bvalid), 64'd1);
      check("bid", 64'(bid), 64'(id));
      check("bresp", 64'(bresp), 64'(resp_exp));
      check("buser", 64'(buser), 64'd0);
      check("wready in resp", 64'(wready), 64'd0);
      for (int k = 0; k < bdelay; k++) begin
         step();
         check("hold bvalid", 64'(bvalid), 64'd1);
         check("hold bid", 64'(bid), 64'(id));
         check("hold bresp", 64'(bresp), 64'(resp_exp));
         check("hold awready", 64'(awready), 64'd0);
         check("hold wr", 64'(wr), 64'd0);
      end
      bready = 1'b1;
      step();
      bready = 1'b0;
      check("b done bvalid", 64'(bvalid), 64'd0);
      check("b done awready", 64'(awready), 64'd1);
      compare_writes("burst");
   endtask

   initial begin
      logic [7:0] rlen;
      int eb;
      // Reset state
      step(); step();
      check("rst awready", 64'(awready), 64'd0);
      check("rst wready", 64'(wready), 64'd0);
      check("rst bvalid", 64'(bvalid), 64'd0);
      check("rst wr", 64'(wr), 64'd0);
      check("rst bid/bresp", 64'({bid, bresp}), 64'd0);
      check("rst waddr/wdata", 64'({waddr, wdata}), 64'd0);
      wvalid = 1'b1; wdat = 32'h1111_2222;
      rst = 1'b0;
      step();
      check("post rst awready", 64'(awready), 64'd1);
      // W offered before any AW is never taken
      step();
      check("early W wr", 64'(wr), 64'd0);
      check("early W wready", 64'(wready), 64'd0);
      wvalid = 1'b0;

      do_burst(8'h5A, 32'h100, 8'd0, 2'b01, -1, 0, 0, 1'b1, 32'hDEADBEEF);
      do_burst(8'h11, 32'h200, 8'd3, 2'b01, -1, 2, 0, 1'b1, 32'd1);
      do_burst(8'h22, 32'h40, 8'd2, 2'b00, -1, 1, 1, 1'b1, 32'hA0);
      do_burst(8'h33, 32'h80, 8'd1, 2'b01, 0, 0, 0, 1'b1, 32'h50);
      do_burst(8'h34, 32'h90, 8'd1, 2'b01, -1, 0, 0, 1'b1, 32'h60);
      do_burst(8'h44, 32'hFFFF_FFFC, 8'd1, 2'b01, -1, 0, 5, 1'b1, 32'h70);
      do_burst(8'h45, 32'h400, 8'd2, 2'b10, 2, 0, 0, 1'b0, 32'h0);

      // Reset after beat 1 of a 4-beat burst
      clear_q();
      send_aw(8'h66, 32'h300, 8'd3, 2'b01);
      for (int i = 0; i < 2; i++) begin
         wdat = 32'hC0 + 32'(i); wstb = 4'hF; wvalid = 1'b1; wlast = 1'b0;
         exp_addr.push_back(32'h300 + 32'(4 * i));
         exp_data.push_back(32'hC0 + 32'(i));
         exp_strb.push_back(4'hF);
         step();
      end
      rst = 1'b1; wdat = 32'hC2;
      step();
      check("mid rst wr", 64'(wr), 64'd0);
      check("mid rst bvalid", 64'(bvalid), 64'd0);
      rst = 1'b0;
      step();
      check("after rst awready", 64'(awready), 64'd1);
      check("after rst wr", 64'(wr), 64'd0);
      check("after rst bvalid", 64'(bvalid), 64'd0);
      step();
      check("after rst stale W", 64'(wr), 64'd0);
      wvalid = 1'b0;
      compare_writes("reset");
      do_burst(8'h67, 32'h500, 8'd2, 2'b01, -1, 1, 1, 1'b0, 32'h0);

      // 256-beat boundary burst, then randomized traffic
      do_burst(8'h77, 32'h1000, 8'd255, 2'b01, -1, 0, 0, 1'b0, 32'h0);
      for (int n = 0; n < 24; n++) begin
         rlen = 8'($urandom_range(0, 9));
         eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, int'(rlen)) : -1;
         do_burst(8'($urandom), $urandom & 32'hFFFF_FFFC, rlen,
                  2'($urandom_range(0, 2)), eb, 2, $urandom_range(0, 3), 1'b0, 32'h0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
